mem_bus_if: RTL

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_bus_if.sv
// Single-access memory bus adapter: latches a request, runs the bus handshake, returns read data.
// Optional MEM_TIMEOUT_EN adds an 8-bit access timeout that completes the access with err=1.
module mem_bus_if (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        mdr_valid,
  output logic [31:0] mdr_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_err;
  logic       timeout_hit;

  // Fires in the cycle the counter would reach 255 with no completion pending.
  assign timeout_hit = (to_cnt == 8'd254) &&
                       (((state == REQ) && !mem_gnt) || ((state == WAIT) && !mem_rvalid));
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = REQ;
      REQ: begin
        if (mem_gnt) state_nx = lat_we ? DONE : WAIT;
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) state_nx = DONE;
`endif
      end
      WAIT: begin
        if (mem_rvalid) state_nx = DONE;
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) state_nx = DONE;
`endif
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if ((state == WAIT) && mem_rvalid) rdata_q <= mem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid) to_cnt <= '0;
      else if ((state == REQ) || (state == WAIT)) to_cnt <= to_cnt + 8'd1;
      to_err <= timeout_hit;
    end
  end

  assign err = (state == DONE) && to_err;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    req_ready = (state == IDLE);
    mem_req   = (state == REQ);
    mem_we    = (state == REQ) && lat_we;
    mem_addr  = (state == REQ) ? (lat_addr & 32'hFFFF_FFFC) : '0;
    mem_wdata = (state == REQ) ? lat_wdata : '0;
    mdr_valid = (state == DONE);
  end

  assign mdr_rdata = rdata_q;

endmodule
